// File: rtl/apb_ram_wide.sv
// APB4 slave RAM with configurable width/depth, byte strobes, wait states and a
// read-only low region; errors (range, misalign, read-only) are reported on pslverr.
module apb_ram_wide #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [31:0]           paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int BYTES = DATA_W / 8;
  localparam int BO    = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [31:0]      ALIGN_MASK = 32'(BYTES - 1);
  localparam logic [31:0]      DEPTH_32   = 32'(DEPTH);
  localparam logic [31:0]      RO_LAST    = 32'(RO_WORDS) - 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(WAIT_CYCLES);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];

  logic [31:0]           word_idx;
  logic [IDX_W-1:0]      idx;
  logic                  range_err;
  logic                  align_err;
  logic                  ro_err;
  logic                  any_err;
  logic                  wr_en;

  // Decode is on the full 32-bit address so high garbage bits still error out.
  assign word_idx  = paddr >> BO;
  assign idx       = word_idx[IDX_W-1:0];
  assign range_err = (word_idx >= DEPTH_32);
  assign align_err = ((paddr & ALIGN_MASK) != 32'd0);
  assign ro_err    = pwrite && (RO_WORDS > 0) && (word_idx <= RO_LAST);
  assign any_err   = range_err || align_err || ro_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (penable) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            pready  = 1'b1;
            state_d = S_IDLE;
            if (any_err) begin
              pslverr = 1'b1;
            end else if (pwrite) begin
              wr_en = 1'b1;
            end else begin
              prdata = mem_q[idx];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (pstrb[i]) mem_d[idx][8*i +: 8] = pwdata[8*i +: 8];
      end
    end
  end

  // Reset wins over a completing write and also clears the storage.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_apb_ram_wide.sv
// Directed bench for apb_ram_wide (32-bit, 16 words, 2 wait states, 2 RO words)
// with a queue-based scoreboard checked by an independent monitor.
module tb_apb_ram_wide;

  logic        pclk = 1'b0;
  logic        preset;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   vecs    = 0;
  int   fails   = 0;
  logic done    = 1'b0;
  logic checked = 1'b0;

  apb_ram_wide #(
    .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(2), .RO_WORDS(2)
  ) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial forever #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: every completion pops one expectation; all other cycles must be quiet.
  always @(negedge pclk) begin
    if (pready) begin
      vecs++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pready cyc=%0d got addr=%h", cyc, paddr);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (pslverr !== x.err || prdata !== x.data || cyc != x.cyc) begin
          fails++;
          $display("FAIL completion cyc=%0d got err=%b data=%h want err=%b data=%h cyc=%0d",
                   cyc, pslverr, prdata, x.err, x.data, x.cyc);
        end
      end
    end else begin
      vecs++;
      if (pslverr !== 1'b0 || prdata !== 32'd0) begin
        fails++;
        $display("FAIL idle_outputs cyc=%0d got err=%b data=%h want err=0 data=0",
                 cyc, pslverr, prdata);
      end
    end
    if (done && !checked) begin
      checked = 1'b1;
      vecs++;
      if (q.size() != 0) begin
        fails++;
        $display("FAIL missing_completions got pending=%0d want 0", q.size());
      end
    end
  end

  // Called #1 after a rising edge: that cycle is SETUP, completion is 3 cycles later.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic e, input logic [31:0] r);
    exp_t x;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
    x.err = e; x.data = r; x.cyc = cyc + 3;
    q.push_back(x);
    @(posedge pclk); #1 penable = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    idle(1);

    xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    xfer(32'h10, 1'b0, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF);
    idle(1);
    xfer(32'h14, 1'b1, 32'h11223344, 4'h5, 1'b0, 32'h0);
    xfer(32'h14, 1'b0, 32'h0,        4'h0, 1'b0, 32'h00220044);
    idle(1);

    xfer(32'h40,       1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    xfer(32'h12,       1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    xfer(32'h40,       1'b0, 32'h0,        4'h0, 1'b1, 32'h0);
    xfer(32'h10000010, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0);
    xfer(32'h12,       1'b0, 32'h0,        4'h0, 1'b1, 32'h0);
    xfer(32'h10,       1'b0, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF);
    xfer(32'h14,       1'b0, 32'h0,        4'h0, 1'b0, 32'h00220044);
    xfer(32'h3C,       1'b1, 32'h12345678, 4'h0, 1'b0, 32'h0);
    xfer(32'h3C,       1'b0, 32'h0,        4'h0, 1'b0, 32'h0);
    xfer(32'h3C,       1'b1, 32'h600DF00D, 4'hF, 1'b0, 32'h0);
    xfer(32'h3C,       1'b0, 32'h0,        4'h0, 1'b0, 32'h600DF00D);
    xfer(32'h10,       1'b1, 32'h11223344, 4'hA, 1'b0, 32'h0);
    xfer(32'h10,       1'b0, 32'h0,        4'h0, 1'b0, 32'h11AD33EF);
    idle(1);

    xfer(32'h04, 1'b1, 32'hA5A5A5A5, 4'hF, 1'b1, 32'h0);
    xfer(32'h04, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0);
    xfer(32'h00, 1'b1, 32'h5A5A5A5A, 4'hF, 1'b1, 32'h0);
    idle(1);

    // Abort: psel drops in the second ACCESS cycle, nothing is pushed.
    psel = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1;
    pwdata = 32'h77777777; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    idle(2);
    xfer(32'h08, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    xfer(32'h10, 1'b0, 32'h0, 4'h0, 1'b0, 32'h11AD33EF);
    idle(1);

    xfer(32'h0C, 1'b1, 32'h12345678, 4'hF, 1'b0, 32'h0);
    xfer(32'h0C, 1'b0, 32'h0,        4'h0, 1'b0, 32'h12345678);
    idle(1);

    // Reset lands in the first ACCESS cycle of a write.
    psel = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1;
    pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0; psel = 1'b0; penable = 1'b0;
    idle(3);
    xfer(32'h0C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    xfer(32'h10, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    xfer(32'h3C, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    idle(2);

    done = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
